// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam logic [KEY_COLS-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB
    } scan_state_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_KEY,
        FR_MULTI
    } frame_result_t;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the keypad row inputs; idles at all-ones (no key down).
module key_sync
    import keypad_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_ROWS-1:0] din,
    output logic [KEY_ROWS-1:0] dout
);

    logic [KEY_ROWS-1:0] meta;

    // Double-register the asynchronous row pins before any logic looks at them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            dout <= '1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 matrix keypad scanner: drives one column low at a time, gathers a full
// frame of row samples, debounces frame results and emits one key event per
// press. Optional auto-repeat of a held key is enabled by defining KEY_REPEAT_EN.
module matrix_key_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV            = 50000,
    parameter int DEBOUNCE_FRAMES     = 4,
    parameter int REPEAT_DELAY_FRAMES = 125,
    parameter int REPEAT_RATE_FRAMES  = 25
) (
    input  logic                clk_50M,
    input  logic                reset,
    input  logic [KEY_ROWS-1:0] KEY_ROW,
    output logic [KEY_COLS-1:0] KEY_COL,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_TARGET  = CW'(DEBOUNCE_FRAMES);

    if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 1 || REPEAT_DELAY_FRAMES < 1 || REPEAT_RATE_FRAMES < 1) begin : g_bad_cfg
        $error("matrix_key_scan: parameter out of range");
    end

    logic [KEY_ROWS-1:0] row_sync;
    logic [DW-1:0]       dwell_cnt;
    logic [1:0]          col_idx;
    logic                sample_tick;
    logic                frame_tick;
    logic [2:0]          col_hits;
    logic [1:0]          col_row;
    logic [2:0]          hit_sum;
    logic [1:0]          acc_count;
    logic [3:0]          acc_code;
    logic [1:0]          merged_count;
    logic [3:0]          merged_code;
    frame_result_t       frame_result;
    scan_state_t         state;
    logic [3:0]          cand;
    logic [CW-1:0]       db_cnt;

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ? REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
    localparam int RW = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] REP_DELAY = RW'(REPEAT_DELAY_FRAMES);
    localparam logic [RW-1:0] REP_RATE  = RW'(REPEAT_RATE_FRAMES);
    logic [RW-1:0] rep_cnt;
    logic          rep_first;
`endif

    key_sync u_sync (
        .clk   (clk_50M),
        .rst_n (reset),
        .din   (KEY_ROW),
        .dout  (row_sync)
    );

    assign sample_tick = (dwell_cnt == DWELL_LAST);
    assign frame_tick  = sample_tick && (col_idx == 2'd3);

    // Column sequencer: dwell SCAN_DIV cycles per column, then rotate the low bit
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
            KEY_COL   <= COL_RESET;
        end else if (sample_tick) begin
            dwell_cnt <= '0;
            col_idx   <= col_idx + 2'd1;
            KEY_COL   <= {KEY_COL[KEY_COLS-2:0], KEY_COL[KEY_COLS-1]};
        end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
        end
    end

    // Merge this column's sample into the running frame tally (count saturates at 2)
    always_comb begin
        col_hits     = 3'd0;
        col_row      = 2'd0;
        hit_sum      = 3'd0;
        merged_count = 2'd0;
        merged_code  = acc_code;
        frame_result = FR_NONE;
        for (int r = 0; r < KEY_ROWS; r++) begin
            if (!row_sync[r]) begin
                col_hits = col_hits + 3'd1;
                col_row  = 2'(r);
            end
        end
        hit_sum      = {1'b0, acc_count} + col_hits;
        merged_count = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        if (col_hits != 3'd0) begin
            merged_code = {col_row, col_idx};
        end
        if (merged_count == 2'd1) begin
            frame_result = FR_KEY;
        end else if (merged_count == 2'd2) begin
            frame_result = FR_MULTI;
        end
    end

    // Frame accumulator: holds partial results for columns 0..2, cleared at frame end
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            acc_count <= 2'd0;
            acc_code  <= 4'd0;
        end else if (frame_tick) begin
            acc_count <= 2'd0;
            acc_code  <= 4'd0;
        end else if (sample_tick) begin
            acc_count <= merged_count;
            acc_code  <= merged_code;
        end
    end

    // Debounce FSM, stepped once per frame; outputs are registered here
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cand      <= 4'd0;
            db_cnt    <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
        end else begin
            key_valid <= 1'b0;
            if (frame_tick) begin
                unique case (state)
                    IDLE: begin
                        if (frame_result == FR_KEY) begin
                            cand   <= merged_code;
                            db_cnt <= CW'(1);
                            if (DEBOUNCE_FRAMES == 1) begin
                                key_valid <= 1'b1;
                                key_code  <= merged_code;
                                key_held  <= 1'b1;
                                db_cnt    <= '0;
                                state     <= HELD;
`ifdef KEY_REPEAT_EN
                                rep_cnt   <= '0;
                                rep_first <= 1'b1;
`endif
                            end else begin
                                state <= PRESS_DB;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (frame_result == FR_KEY && merged_code == cand) begin
                            if (db_cnt + CW'(1) == DB_TARGET) begin
                                key_valid <= 1'b1;
                                key_code  <= cand;
                                key_held  <= 1'b1;
                                db_cnt    <= '0;
                                state     <= HELD;
`ifdef KEY_REPEAT_EN
                                rep_cnt   <= '0;
                                rep_first <= 1'b1;
`endif
                            end else begin
                                db_cnt <= db_cnt + CW'(1);
                            end
                        end else if (frame_result == FR_KEY) begin
                            cand   <= merged_code;
                            db_cnt <= CW'(1);
                        end else begin
                            db_cnt <= '0;
                            state  <= IDLE;
                        end
                    end
                    HELD: begin
                        if (frame_result == FR_NONE) begin
                            if (DEBOUNCE_FRAMES == 1) begin
                                key_held <= 1'b0;
                                db_cnt   <= '0;
                                state    <= IDLE;
`ifdef KEY_REPEAT_EN
                                rep_cnt   <= '0;
                                rep_first <= 1'b1;
`endif
                            end else begin
                                db_cnt <= CW'(1);
                                state  <= REL_DB;
                            end
                        end
`ifdef KEY_REPEAT_EN
                        else if (rep_cnt + RW'(1) == (rep_first ? REP_DELAY : REP_RATE)) begin
                            key_valid <= 1'b1;
                            rep_cnt   <= '0;
                            rep_first <= 1'b0;
                        end else begin
                            rep_cnt <= rep_cnt + RW'(1);
                        end
`endif
                    end
                    REL_DB: begin
                        if (frame_result == FR_NONE) begin
                            if (db_cnt + CW'(1) == DB_TARGET) begin
                                key_held <= 1'b0;
                                db_cnt   <= '0;
                                state    <= IDLE;
`ifdef KEY_REPEAT_EN
                                rep_cnt   <= '0;
                                rep_first <= 1'b1;
`endif
                            end else begin
                                db_cnt <= db_cnt + CW'(1);
                            end
                        end else begin
                            db_cnt <= '0;
                            state  <= HELD;
                        end
                    end
                endcase
            end
        end
    end

endmodule
